mips_muldiv: RTL and testbench

Iterative multiply/divide unit beside the MIPS ALU, downstream of the register file. It consumes the same A/B operand buses the ALU reads and produces the HI/LO results used by MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. It uses a one-bit-per-cycle shift-add multiplier and a restoring divider, with a start/busy/done handshake so the controller can stall while the unit runs.

---
 rtl/mips_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_mips_muldiv.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with a one-bit-per-cycle datapath.
// The multiplier is shift-add and the divider is restoring.
// Results go to the HI/LO registers.
// A start/busy/done handshake lets the pipeline controller stall on it.
module mips_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int                  CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};

    // Two's complement negation of a single word.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Two's complement negation of the double-width product.
    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                is_div_r;
    logic                sign_q_r;
    logic                sign_r_r;
    logic [DATA_W-1:0]   mcand_r;    // multiplicand magnitude or divisor magnitude
    logic [2*DATA_W-1:0] acc_r;      // {hi, lo} for mult, {rem, quo} for div
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                busy_r;
    logic                done_r;
    logic                dbz_r;

    logic                a_neg_s;
    logic                b_neg_s;
    logic [DATA_W-1:0]   a_mag_s;
    logic [DATA_W-1:0]   b_mag_s;
    logic [DATA_W:0]     mul_sum_s;
    logic [DATA_W:0]     rem_sh_s;
    logic [DATA_W-1:0]   diff_s;
    logic [2*DATA_W-1:0] step_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   fix_hi_s;
    logic [DATA_W-1:0]   fix_lo_s;

    // Operand magnitudes at acceptance; op[0] marks the signed variants.
    always_comb begin
        a_neg_s = op[0] & A[DATA_W-1];
        b_neg_s = op[0] & B[DATA_W-1];
        a_mag_s = a_neg_s ? neg_w(A) : A;
        b_mag_s = b_neg_s ? neg_w(B) : B;
    end

    // One multiply or restoring-divide iteration on the accumulator.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
        rem_sh_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        diff_s    = rem_sh_s[DATA_W-1:0] - mcand_r;
        step_s    = acc_r;
        if (is_div_r) begin
            if (rem_sh_s >= {1'b0, mcand_r}) begin
                step_s = {diff_s, acc_r[DATA_W-2:0], 1'b1};
            end else begin
                step_s = {rem_sh_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, mcand_r};
            end else begin
                mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
            end
            step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end
    end

    // Sign fix-up of the magnitude result; unsigned ops carry zero sign flags.
    always_comb begin
        prod_s = sign_q_r ? neg_2w(acc_r) : acc_r;
        quo_s  = sign_q_r ? neg_w(acc_r[DATA_W-1:0]) : acc_r[DATA_W-1:0];
        rem_s  = sign_r_r ? neg_w(acc_r[2*DATA_W-1:DATA_W]) : acc_r[2*DATA_W-1:DATA_W];
        if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[2*DATA_W-1:DATA_W];
            fix_lo_s = prod_s[DATA_W-1:0];
        end
    end

    // Control FSM, iteration datapath, HI/LO registers and handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            is_div_r <= 1'b0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            mcand_r  <= ZERO_W;
            acc_r    <= {ZERO_W, ZERO_W};
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    if (start) begin
                        is_div_r <= op[1];
                        sign_q_r <= a_neg_s ^ b_neg_s;
                        sign_r_r <= a_neg_s;
                        cnt_r    <= CNT_ZERO;
                        if (op[1]) begin
                            mcand_r <= b_mag_s;
                            acc_r   <= {ZERO_W, a_mag_s};
                        end else begin
                            mcand_r <= a_mag_s;
                            acc_r   <= {ZERO_W, b_mag_s};
                        end
                        if (op[1] && (B == ZERO_W)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) state_r <= ST_FIX;
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign HI          = hi_r;
    assign LO          = lo_r;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv.
// It runs directed and random operations against an arithmetic reference model.
module tb_mips_muldiv;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    mips_muldiv #(.DATA_W(W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the MIPS semantics.
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic dz);
        longint sa, sb;
        logic [63:0] p, q, r;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            2'b01: begin
                p = sa * sb;
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            2'b10: begin
                if (b == 0) dz = 1'b1;
                else begin lo_m = a / b; hi_m = a % b; end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit pre_we, input logic [W-1:0] pre_d,
                          input int inject_at);
        logic dz;
        int lat, busy_n;
        bit seen;
        @(negedge CLK);
        op = o; A = a; B = b; start = 1'b1; hi_we = pre_we; wdata = pre_d;
        if (pre_we) hi_m = pre_d;
        @(negedge CLK);
        start = 1'b0; hi_we = 1'b0;
        if (pre_we) chk({tag, "_mthi_same_edge"}, HI, pre_d);
        model_op(o, a, b, dz);
        lat = 0; busy_n = 0; seen = 1'b0;
        while (lat < 60 && !seen) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) busy_n++;
                if (lat == inject_at) begin
                    start = 1'b1; op = ~o; A = $urandom; B = $urandom;
                    hi_we = 1'b1; wdata = 32'h55;
                end
                @(negedge CLK);
                start = 1'b0; hi_we = 1'b0;
                lat++;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(lat), dz ? 64'd0 : 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_n), dz ? 64'd0 : 64'd33);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(dz));
        chk({tag, "_hi"}, 64'(HI), 64'(hi_m));
        chk({tag, "_lo"}, 64'(LO), 64'(lo_m));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_dbz_clear"}, 64'(div_by_zero), 64'd0);
        chk({tag, "_hi_held"}, 64'(HI), 64'(hi_m));
    endtask

    initial begin
        int done_n;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        RESET = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge CLK);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        chk("reset_hi", 64'(HI), 64'd0);
        chk("reset_lo", 64'(LO), 64'd0);
        RESET = 1'b0;

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, -1);
        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 32'h0, -1);
        run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, -1);
        run_op("divu_13_4", 2'b10, 32'd13, 32'd4, 1'b0, 32'h0, -1);

        // Preload HI/LO with MTHI / MTLO, then divide by zero.
        @(negedge CLK); hi_we = 1'b1; wdata = 32'h11;
        @(negedge CLK); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge CLK); lo_we = 1'b0;
        hi_m = 32'h11; lo_m = 32'h22;
        chk("mthi", 64'(HI), 64'h11);
        chk("mtlo", 64'(LO), 64'h22);
        run_op("divu_by_zero", 2'b10, 32'd13, 32'd0, 1'b0, 32'h0, -1);

        run_op("div_wrap", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, -1);
        run_op("mult_minmin", 2'b01, 32'h80000000, 32'h80000000, 1'b0, 32'h0, -1);
        run_op("multu_inject", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0, 10);
        run_op("mthi_with_start", 2'b00, 32'd2, 32'd3, 1'b1, 32'hAA, -1);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge CLK); start = 1'b1; op = 2'b01; A = $urandom; B = $urandom;
        @(negedge CLK); start = 1'b0;
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        hi_m = '0; lo_m = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(HI), 64'd0);
        chk("abort_lo", 64'(LO), 64'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_n++;
            @(negedge CLK);
        end
        chk("abort_no_done", 64'(done_n), 64'd0);

        for (int k = 0; k < 16; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, 1'b0, 32'h0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
